// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR / trap controller.
// Holds CSR addresses, instruction encodings, cause codes, field positions
// and field masks.
// The 64-bit counter addresses are decoded only when CSR_COUNTERS_EN is defined.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // csr_opcode encodings; bits [1:0] select the write operation
    typedef enum logic [2:0] {
        OP_SYSTEM = 3'b000,
        OP_RW     = 3'b001,
        OP_RS     = 3'b010,
        OP_RC     = 3'b011,
        OP_RSV    = 3'b100,
        OP_RWI    = 3'b101,
        OP_RSI    = 3'b110,
        OP_RCI    = 3'b111
    } csr_op_e;

    // sys_inst encodings (only valid with OP_SYSTEM)
    typedef enum logic [1:0] {
        SYS_ECALL = 2'b00,
        SYS_RSV1  = 2'b01,
        SYS_RSV2  = 2'b10,
        SYS_MRET  = 2'b11
    } sys_inst_e;

    // Cause codes
    localparam logic [4:0] CAUSE_ECALL_M  = 5'd11;
    localparam logic [4:0] CAUSE_IRQ_BASE = 5'd16;

    // Field positions and masks
    localparam int          MSTATUS_MIE_BIT  = 3;
    localparam int          MSTATUS_MPIE_BIT = 7;
    localparam int          MTVEC_MODE_BIT   = 0;
    localparam int          IRQ_LSB          = 16;
    localparam logic [31:0] MSTATUS_MPP      = 32'h0000_1800;
    localparam logic [31:0] MISA_VALUE       = 32'h4000_1100;
    localparam logic [31:0] MTVEC_MASK       = 32'hFFFF_FFFD;
    localparam logic [31:0] MEPC_MASK        = 32'hFFFF_FFFC;

    // RW / RS / RC applied to the old CSR value
    function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        case (op)
            2'b01:   return wdata;
            2'b10:   return old_val | wdata;
            default: return old_val & ~wdata;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes.
// Ports: clk/rst (async active-low), inc (count enable), wr_lo/wr_hi
// (load wdata into that half, replacing this cycle's increment for it),
// wdata (write data), value (current count).
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] value_q, value_d;

    // Increment first, then let a write take over its half; wraps naturally.
    always_comb begin
        value_d = value_q + {63'b0, inc};
        if (wr_lo) value_d[31:0]  = wdata;
        if (wr_hi) value_d[63:32] = wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) value_q <= '0;
        else      value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file with interrupt / ECALL / MRET trap control.
// Ports: clk, rst (async active-low), pc_i (current PC), irq_i (level irqs),
// csr_en/csr_opcode/sys_inst/addr/csr_data_wr (CSR or system instruction),
// stop_fetch/jump (block interrupt entry), retire_i (minstret increment),
// csr_data_out (combinational pre-write read data), trap_o/trap_pc_o
// (registered one-cycle redirect), mie_bit (mstatus.MIE).
// Optional feature: define CSR_COUNTERS_EN to add mcycle/minstret.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              NUM_IRQ     = 2,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               csr_en,
    input  logic [2:0]         csr_opcode,
    input  logic [1:0]         sys_inst,
    input  logic [11:0]        addr,
    input  logic [XLEN-1:0]    csr_data_wr,
    input  logic               stop_fetch,
    input  logic               jump,
    input  logic               retire_i,
    output logic [XLEN-1:0]    csr_data_out,
    output logic               trap_o,
    output logic [XLEN-1:0]    trap_pc_o,
    output logic               mie_bit
);

    logic               mie_q, mie_d, mpie_q, mpie_d;
    logic [NUM_IRQ-1:0] irq_en_q, irq_en_d, mip_q;
    logic [XLEN-1:0]    mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0]    mepc_q, mepc_d, mcause_q, mcause_d;
    logic               trap_q, trap_d;
    logic [XLEN-1:0]    trap_pc_q, trap_pc_d;
    logic [XLEN-1:0]    rdata, wval, trap_base;
    logic [NUM_IRQ-1:0] pending;
    logic [3:0]         irq_idx;
    logic [4:0]         irq_cause;
    logic               is_sys, do_ecall, do_mret, is_wr, irq_take, wr_ok;

    assign is_sys   = csr_en && (csr_op_e'(csr_opcode) == OP_SYSTEM);
    assign do_ecall = is_sys && (sys_inst_e'(sys_inst) == SYS_ECALL);
    assign do_mret  = is_sys && (sys_inst_e'(sys_inst) == SYS_MRET);
    // Opcode 100 is reserved and does nothing.
    assign is_wr    = csr_en && (csr_opcode[1:0] != 2'b00);
    assign pending  = mip_q & irq_en_q;
    assign irq_take = mie_q && (|pending) && !stop_fetch && !jump;
    // An interrupt in the same cycle swallows the CSR write entirely.
    assign wr_ok    = is_wr && !irq_take;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_val, minstret_val;

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (wr_ok && (addr == CSR_MCYCLE)),
        .wr_hi (wr_ok && (addr == CSR_MCYCLEH)),
        .wdata (wval),
        .value (mcycle_val)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_i),
        .wr_lo (wr_ok && (addr == CSR_MINSTRET)),
        .wr_hi (wr_ok && (addr == CSR_MINSTRETH)),
        .wdata (wval),
        .value (minstret_val)
    );
`else
    logic unused_retire;
    assign unused_retire = retire_i;
`endif

    // Read mux: also provides the old value for RS/RC.
    always_comb begin
        rdata = '0;
        case (addr)
            CSR_MSTATUS: begin
                rdata                   = MSTATUS_MPP;
                rdata[MSTATUS_MIE_BIT]  = mie_q;
                rdata[MSTATUS_MPIE_BIT] = mpie_q;
            end
            CSR_MISA:     rdata = MISA_VALUE;
            CSR_MIE:      rdata[IRQ_LSB +: NUM_IRQ] = irq_en_q;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MIP:      rdata[IRQ_LSB +: NUM_IRQ] = mip_q;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    rdata = mcycle_val[31:0];
            CSR_MCYCLEH:   rdata = mcycle_val[63:32];
            CSR_MINSTRET:  rdata = minstret_val[31:0];
            CSR_MINSTRETH: rdata = minstret_val[63:32];
`endif
            default:      rdata = '0;
        endcase
    end

    assign wval      = csr_apply(csr_opcode[1:0], rdata, csr_data_wr);
    assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};

    // Lowest-indexed pending line wins: scan downwards so the last hit is lowest.
    always_comb begin
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) irq_idx = 4'(i);
        end
    end

    assign irq_cause = CAUSE_IRQ_BASE + {1'b0, irq_idx};

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        irq_en_d   = irq_en_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        trap_d     = 1'b0;
        trap_pc_d  = trap_pc_q;

        if (irq_take) begin
            mepc_d    = pc_i & MEPC_MASK;
            mcause_d  = {1'b1, {(XLEN-6){1'b0}}, irq_cause};
            mpie_d    = mie_q;
            mie_d     = 1'b0;
            trap_d    = 1'b1;
            trap_pc_d = mtvec_q[MTVEC_MODE_BIT]
                      ? trap_base + {{(XLEN-7){1'b0}}, irq_cause, 2'b00}
                      : trap_base;
        end else if (do_ecall) begin
            mepc_d    = pc_i & MEPC_MASK;
            mcause_d  = {{(XLEN-5){1'b0}}, CAUSE_ECALL_M};
            mpie_d    = mie_q;
            mie_d     = 1'b0;
            trap_d    = 1'b1;
            trap_pc_d = trap_base;
        end else if (do_mret) begin
            mie_d     = mpie_q;
            mpie_d    = 1'b1;
            trap_d    = 1'b1;
            trap_pc_d = mepc_q;
        end else if (wr_ok) begin
            case (addr)
                CSR_MSTATUS: begin
                    mie_d  = wval[MSTATUS_MIE_BIT];
                    mpie_d = wval[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      irq_en_d   = wval[IRQ_LSB +: NUM_IRQ];
                CSR_MTVEC:    mtvec_d    = wval & MTVEC_MASK;
                CSR_MSCRATCH: mscratch_d = wval;
                CSR_MEPC:     mepc_d     = wval & MEPC_MASK;
                CSR_MCAUSE:   mcause_d   = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            irq_en_q   <= '0;
            mip_q      <= '0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            trap_q     <= 1'b0;
            trap_pc_q  <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            irq_en_q   <= irq_en_d;
            mip_q      <= irq_i;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            trap_q     <= trap_d;
            trap_pc_q  <= trap_pc_d;
        end
    end

    assign csr_data_out = csr_en ? rdata : '0;
    assign trap_o       = trap_q;
    assign trap_pc_o    = trap_pc_q;
    assign mie_bit      = mie_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;

    localparam logic [31:0] RST_MTVEC = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic [1:0]  irq_i;
    logic        csr_en;
    logic [2:0]  csr_opcode;
    logic [1:0]  sys_inst;
    logic [11:0] addr;
    logic [31:0] csr_data_wr;
    logic        stop_fetch, jump, retire_i;
    logic [31:0] csr_data_out;
    logic        trap_o;
    logic [31:0] trap_pc_o;
    logic        mie_bit;

    int npass = 0;
    int ntotal = 0;

    csr_trap_ctrl #(.XLEN(32), .NUM_IRQ(2), .RESET_MTVEC(RST_MTVEC)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .irq_i(irq_i), .csr_en(csr_en),
        .csr_opcode(csr_opcode), .sys_inst(sys_inst), .addr(addr),
        .csr_data_wr(csr_data_wr), .stop_fetch(stop_fetch), .jump(jump),
        .retire_i(retire_i), .csr_data_out(csr_data_out), .trap_o(trap_o),
        .trap_pc_o(trap_pc_o), .mie_bit(mie_bit)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One CSR instruction cycle; returns csr_data_out sampled mid-cycle.
    task automatic csr_cycle(input logic [2:0] op, input logic [11:0] a,
                             input logic [31:0] wd, output logic [31:0] rd);
        csr_en = 1'b1; csr_opcode = op; addr = a; csr_data_wr = wd;
        @(negedge clk);
        rd = csr_data_out;
        @(posedge clk); #1;
        csr_en = 1'b0;
    endtask

    task automatic csr_read_check(input string nm, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        csr_cycle(3'b010, a, 32'h0, rd);
        check(nm, rd, exp);
    endtask

    task automatic sys_cycle(input logic [1:0] s);
        csr_en = 1'b1; csr_opcode = 3'b000; sys_inst = s; addr = 12'h0;
        @(posedge clk); #1;
        csr_en = 1'b0;
    endtask

    task automatic wait_trap(input int maxc, output logic seen, output logic [31:0] tpc);
        seen = 1'b0; tpc = '0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (trap_o) begin seen = 1'b1; tpc = trap_pc_o; end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [11:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic        m_mie, m_mpie;
    logic [1:0]  m_ien, m_mip;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic        m_trap;
    logic [31:0] m_tpc;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h301: return 32'h4000_1100;
            12'h304: return 32'(m_ien) << 16;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return 32'(m_mip) << 16;
            default: return 32'h0;
        endcase
    endfunction

    logic [11:0] rand_addrs[10] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                                    12'h341, 12'h342, 12'h344, 12'h7C0, 12'h343};

    initial begin
        logic [31:0] rd, tpc, oldv, nv, base;
        logic        seen, any_trap;
        logic [1:0]  pend;
        logic [4:0]  cause;
        logic        tmp;

        rst = 1'b0; pc_i = '0; irq_i = '0; csr_en = 1'b0; csr_opcode = '0;
        sys_inst = '0; addr = '0; csr_data_wr = '0; stop_fetch = 1'b0;
        jump = 1'b0; retire_i = 1'b0;
        #1;
        check("reset_trap_o", {31'b0, trap_o}, 32'h0);
        check("reset_mie_bit", {31'b0, mie_bit}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // ---------------- table-driven CSR vectors ----------------
        vecs.push_back('{1'b1, 3'b010, 12'h300, 32'h0,         32'h0000_1800});
        vecs.push_back('{1'b1, 3'b010, 12'h305, 32'h0,         RST_MTVEC});
        vecs.push_back('{1'b1, 3'b010, 12'h301, 32'h0,         32'h4000_1100});
        vecs.push_back('{1'b1, 3'b001, 12'h340, 32'h0F,        32'h0});
        vecs.push_back('{1'b1, 3'b010, 12'h340, 32'hF0,        32'h0F});
        vecs.push_back('{1'b1, 3'b010, 12'h340, 32'h0,         32'hFF});
        vecs.push_back('{1'b1, 3'b001, 12'h301, 32'h0,         32'h4000_1100});
        vecs.push_back('{1'b1, 3'b010, 12'h301, 32'h0,         32'h4000_1100});
        vecs.push_back('{1'b1, 3'b001, 12'h341, 32'h123,       32'h0});
        vecs.push_back('{1'b1, 3'b010, 12'h341, 32'h0,         32'h120});
        vecs.push_back('{1'b1, 3'b101, 12'h305, 32'hFFFF_FFFF, RST_MTVEC});
        vecs.push_back('{1'b1, 3'b010, 12'h305, 32'h0,         32'hFFFF_FFFD});
        vecs.push_back('{1'b1, 3'b111, 12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{1'b1, 3'b010, 12'h305, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'b001, 12'h304, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 12'h304, 32'h0,         32'h0003_0000});
        vecs.push_back('{1'b1, 3'b011, 12'h304, 32'hFFFF_FFFF, 32'h0003_0000});
        vecs.push_back('{1'b1, 3'b010, 12'h304, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'b110, 12'h342, 32'h1F,        32'h0});
        vecs.push_back('{1'b1, 3'b010, 12'h342, 32'h0,         32'h1F});
        vecs.push_back('{1'b1, 3'b001, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800});
        vecs.push_back('{1'b1, 3'b010, 12'h300, 32'h0,         32'h0000_1888});
        vecs.push_back('{1'b1, 3'b011, 12'h300, 32'h88,        32'h0000_1888});
        vecs.push_back('{1'b1, 3'b010, 12'h300, 32'h0,         32'h0000_1800});
        vecs.push_back('{1'b0, 3'b001, 12'h300, 32'h0000_0008, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 12'h300, 32'h0,         32'h0000_1800});
        vecs.push_back('{1'b1, 3'b010, 12'h7C0, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'b001, 12'h344, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 12'h344, 32'h0,         32'h0});

        foreach (vecs[i]) begin
            csr_en = vecs[i].en; csr_opcode = vecs[i].op; addr = vecs[i].a;
            csr_data_wr = vecs[i].wd;
            @(negedge clk);
            check($sformatf("vec%0d_rd_%h", i, vecs[i].a), csr_data_out, vecs[i].exp);
            @(posedge clk); #1;
        end
        csr_en = 1'b0;

        // ---------------- vectored interrupt entry ----------------
        csr_cycle(3'b001, 12'h304, 32'h0001_0000, rd);
        csr_cycle(3'b001, 12'h305, 32'h0000_0101, rd);
        irq_i = 2'b01;
        csr_read_check("mip_not_yet", 12'h344, 32'h0);
        csr_read_check("mip_visible", 12'h344, 32'h0001_0000);
        pc_i = 32'h40;
        csr_cycle(3'b010, 12'h300, 32'h8, rd);
        wait_trap(5, seen, tpc);
        check("irq_trap_seen", {31'b0, seen}, 32'h1);
        check("irq_trap_pc", tpc, 32'h140);
        @(negedge clk);
        check("irq_pulse_width", {31'b0, trap_o}, 32'h0);
        @(posedge clk); #1;
        irq_i = 2'b00;
        check("irq_mie_cleared", {31'b0, mie_bit}, 32'h0);
        csr_read_check("irq_mepc", 12'h341, 32'h40);
        csr_read_check("irq_mcause", 12'h342, 32'h8000_0010);
        csr_read_check("irq_mstatus", 12'h300, 32'h0000_1880);

        // ---------------- priority between lines, stall gating ----------------
        csr_cycle(3'b001, 12'h304, 32'h0003_0000, rd);
        irq_i = 2'b11; stop_fetch = 1'b1;
        csr_cycle(3'b010, 12'h300, 32'h8, rd);
        any_trap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any_trap = any_trap | trap_o;
            @(posedge clk); #1;
        end
        check("stall_no_trap", {31'b0, any_trap}, 32'h0);
        stop_fetch = 1'b0;
        wait_trap(5, seen, tpc);
        check("stall_release_trap", {31'b0, seen}, 32'h1);
        check("two_irq_pc", tpc, 32'h140);
        irq_i = 2'b00;
        csr_read_check("two_irq_mcause", 12'h342, 32'h8000_0010);

        // ---------------- ECALL then MRET ----------------
        csr_cycle(3'b010, 12'h300, 32'h8, rd);
        pc_i = 32'h80;
        sys_cycle(2'b00);
        wait_trap(3, seen, tpc);
        check("ecall_seen", {31'b0, seen}, 32'h1);
        check("ecall_pc", tpc, 32'h100);
        check("ecall_mie", {31'b0, mie_bit}, 32'h0);
        csr_read_check("ecall_mcause", 12'h342, 32'd11);
        csr_read_check("ecall_mepc", 12'h341, 32'h80);
        pc_i = 32'h300;
        sys_cycle(2'b11);
        wait_trap(3, seen, tpc);
        check("mret_seen", {31'b0, seen}, 32'h1);
        check("mret_pc", tpc, 32'h80);
        check("mret_mie", {31'b0, mie_bit}, 32'h1);
        csr_read_check("mret_mstatus", 12'h300, 32'h0000_1888);

        // ---------------- interrupt beats a same-cycle CSR write ----------------
        irq_i = 2'b01;
        idle_cycle();
        csr_cycle(3'b001, 12'h340, 32'hDEAD_BEEF, rd);
        check("prio_read_old", rd, 32'hFF);
        wait_trap(3, seen, tpc);
        check("prio_trap_seen", {31'b0, seen}, 32'h1);
        irq_i = 2'b00;
        csr_read_check("prio_write_dropped", 12'h340, 32'hFF);

        // ---------------- reset while a trap pulse is due ----------------
        sys_cycle(2'b00);
        rst = 1'b0;
        #1;
        check("midtrap_reset_trap_o", {31'b0, trap_o}, 32'h0);
        csr_en = 1'b1; csr_opcode = 3'b010; addr = 12'h305; csr_data_wr = '0;
        #1;
        check("midtrap_reset_mtvec", csr_data_out, RST_MTVEC);
        csr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("after_reset_trap_o", {31'b0, trap_o}, 32'h0);

        // ---------------- counters ----------------
`ifdef CSR_COUNTERS_EN
        csr_cycle(3'b001, 12'hB80, 32'h0, rd);
        csr_cycle(3'b001, 12'hB00, 32'hFFFF_FFFF, rd);
        csr_read_check("mcycle_lo_set", 12'hB00, 32'hFFFF_FFFF);
        csr_read_check("mcycle_lo_wrap", 12'hB00, 32'h0);
        csr_read_check("mcycle_hi_carry", 12'hB80, 32'h1);
        retire_i = 1'b1;
        csr_cycle(3'b001, 12'hB02, 32'h5, rd);
        retire_i = 1'b0;
        csr_read_check("minstret_override", 12'hB02, 32'h5);
        retire_i = 1'b1;
        idle_cycle();
        retire_i = 1'b0;
        csr_read_check("minstret_inc", 12'hB02, 32'h6);
`else
        csr_read_check("no_counter_rd", 12'hB00, 32'h0);
        csr_cycle(3'b001, 12'hB00, 32'h1234, rd);
        csr_read_check("no_counter_wr", 12'hB00, 32'h0);
`endif

        // ---------------- randomized run against the reference model ----------------
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        m_mie = 1'b0; m_mpie = 1'b0; m_ien = '0; m_mip = '0;
        m_mtvec = RST_MTVEC; m_mscratch = '0; m_mepc = '0; m_mcause = '0;
        m_trap = 1'b0; m_tpc = '0;

        for (int c = 0; c < 400; c++) begin
            irq_i       = 2'($urandom_range(0, 3));
            stop_fetch  = ($urandom_range(0, 3) == 0);
            jump        = ($urandom_range(0, 5) == 0);
            pc_i        = $urandom & 32'hFFFF_FFFC;
            csr_en      = ($urandom_range(0, 2) != 0);
            csr_opcode  = 3'($urandom_range(0, 7));
            if (csr_opcode == 3'b100) csr_opcode = 3'b001;
            sys_inst    = 2'($urandom_range(0, 3));
            addr        = rand_addrs[$urandom_range(0, 9)];
            csr_data_wr = $urandom;
            retire_i    = 1'($urandom_range(0, 1));

            @(negedge clk);
            check($sformatf("rnd%0d_rd", c), csr_data_out, csr_en ? m_read(addr) : 32'h0);
            check($sformatf("rnd%0d_trap", c), {31'b0, trap_o}, {31'b0, m_trap});
            if (m_trap) check($sformatf("rnd%0d_tpc", c), trap_pc_o, m_tpc);
            check($sformatf("rnd%0d_mie", c), {31'b0, mie_bit}, {31'b0, m_mie});

            // Model: what the spec says happens at this clock edge
            pend = m_mip & m_ien;
            base = {m_mtvec[31:2], 2'b00};
            m_trap = 1'b0;
            if (m_mie && pend != 2'b00 && !stop_fetch && !jump) begin
                cause = pend[0] ? 5'd16 : 5'd17;
                m_trap = 1'b1;
                m_tpc = m_mtvec[0] ? base + 32'(cause) * 4 : base;
                m_mepc = pc_i;
                m_mcause = 32'h8000_0000 + 32'(cause);
                m_mpie = m_mie;
                m_mie = 1'b0;
            end else if (csr_en && csr_opcode == 3'b000 && sys_inst == 2'b00) begin
                m_trap = 1'b1;
                m_tpc = base;
                m_mepc = pc_i;
                m_mcause = 32'd11;
                m_mpie = m_mie;
                m_mie = 1'b0;
            end else if (csr_en && csr_opcode == 3'b000 && sys_inst == 2'b11) begin
                m_trap = 1'b1;
                m_tpc = m_mepc;
                tmp = m_mpie;
                m_mie = tmp;
                m_mpie = 1'b1;
            end else if (csr_en && csr_opcode != 3'b000) begin
                oldv = m_read(addr);
                case (csr_opcode % 4)
                    1:       nv = csr_data_wr;
                    2:       nv = oldv | csr_data_wr;
                    default: nv = oldv & ~csr_data_wr;
                endcase
                case (addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_ien = nv[17:16];
                    12'h305: m_mtvec = nv & 32'hFFFF_FFFD;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & 32'hFFFF_FFFC;
                    12'h342: m_mcause = nv;
                    default: ;
                endcase
            end
            m_mip = irq_i;
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
